// File: rtl/wave_param_loader.sv
// ============================================================================
// Module   : wave_param_loader
// Purpose  : Byte-serial loader for the 8-channel summing synth. 3-byte write
//            frames fill shadow registers; a COMMIT frame swaps all shadows onto
//            the active amps/offsets/phasewords buses in a single edge.
// Options  : PARAM_TIMEOUT_EN - abort partial frames after TIMEOUT_CYCLES idle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wave_param_loader #(
    parameter int NCH = 8
`ifdef PARAM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 err_clr,
    output logic [16*NCH-1:0]    amps,
    output logic [16*NCH-1:0]    offsets,
    output logic [16*NCH-1:0]    phasewords,
    output logic                 commit_done,
    output logic                 frame_err,
    output logic                 err_sticky
);

    localparam int c_W = 16 * NCH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DATA_HI = 2'd1,
        S_DATA_LO = 2'd2,
        S_COMMIT  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cmd;
    logic [2:0]       r_chan;
    logic [7:0]       r_hi;
    logic [c_W-1:0]   r_sh_amp;
    logic [c_W-1:0]   r_sh_off;
    logic [c_W-1:0]   r_sh_pw;
    logic [c_W-1:0]   r_amps;
    logic [c_W-1:0]   r_offs;
    logic [c_W-1:0]   r_pws;
    logic             r_commit_done;
    logic             r_frame_err;
    logic             r_err_sticky;
    logic             w_accept;
    logic             w_timeout;
    logic             w_err_nxt;
    logic             w_commit_nxt;
    logic             w_wr;

    assign in_ready = (r_state != S_COMMIT);
    assign w_accept = in_valid && in_ready;

`ifdef PARAM_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_in_frame;

    assign w_in_frame = (r_state == S_DATA_HI) || (r_state == S_DATA_LO);
    // A byte arriving on the expiry cycle still wins, so nothing is dropped.
    assign w_timeout  = w_in_frame && !w_accept && (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (w_accept || !w_in_frame || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_err_nxt    = 1'b0;
        w_commit_nxt = 1'b0;
        w_wr         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (in_data[5:3] != 3'b000) begin
                        w_err_nxt = 1'b1;
                    end else if (in_data[7:6] == 2'b11) begin
                        w_state_nxt = S_COMMIT;
                    end else begin
                        w_state_nxt = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (w_accept) begin
                    w_wr        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_COMMIT: begin
                w_commit_nxt = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd         <= 2'b00;
            r_chan        <= 3'b000;
            r_hi          <= 8'h00;
            r_sh_amp      <= '0;
            r_sh_off      <= '0;
            r_sh_pw       <= '0;
            r_amps        <= '0;
            r_offs        <= '0;
            r_pws         <= '0;
            r_commit_done <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_sticky  <= 1'b0;
        end else begin
            r_commit_done <= w_commit_nxt;
            r_frame_err   <= w_err_nxt;
            // A fresh error outranks a simultaneous clear.
            if (w_err_nxt) begin
                r_err_sticky <= 1'b1;
            end else if (err_clr) begin
                r_err_sticky <= 1'b0;
            end
            if ((r_state == S_IDLE) && w_accept) begin
                r_cmd  <= in_data[7:6];
                r_chan <= in_data[2:0];
            end
            if ((r_state == S_DATA_HI) && w_accept) begin
                r_hi <= in_data;
            end
            for (int n = 0; n < NCH; n++) begin
                if (w_wr && (r_chan == 3'(n))) begin
                    case (r_cmd)
                        2'b00:   r_sh_amp[16*n +: 16] <= {r_hi, in_data};
                        2'b01:   r_sh_off[16*n +: 16] <= {r_hi, in_data};
                        2'b10:   r_sh_pw[16*n +: 16]  <= {r_hi, in_data};
                        default: ;
                    endcase
                end
            end
            if (w_commit_nxt) begin
                r_amps <= r_sh_amp;
                r_offs <= r_sh_off;
                r_pws  <= r_sh_pw;
            end
        end
    end

    assign amps        = r_amps;
    assign offsets     = r_offs;
    assign phasewords  = r_pws;
    assign commit_done = r_commit_done;
    assign frame_err   = r_frame_err;
    assign err_sticky  = r_err_sticky;

endmodule

`default_nettype wire
